// File: rtl/mem_dump_reader.sv
// ----------------------------------------------------------------------------
// mem_dump_reader
//
// Debug-side reader for the data memory of the memory-access stage. A start
// pulse (accepted only while idle) makes it walk the memory word by word from
// byte address 0. Each word goes out as NBITS/8 bytes, MSB first, through the
// uart_tx byte handshake. It sits in the debug unit, between the data-memory
// read port and uart_tx.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst        asynchronous reset, active-low
//   i_start      start-dump request, sampled only while idle
//   o_mem_rd_en  data-memory read strobe, one cycle per word
//   o_mem_addr   word-aligned byte address (word_idx * 4)
//   i_mem_data   read data, valid the cycle after o_mem_rd_en
//   o_tx_data    byte to transmit (held while waiting for i_tx_done)
//   o_tx_start   one-cycle pulse: uart_tx loads o_tx_data
//   i_tx_done    one-cycle pulse from uart_tx: byte fully sent
//   o_busy       high in every state except idle
//   o_done       one-cycle pulse after the last byte of the last word
// ----------------------------------------------------------------------------
module mem_dump_reader #(
  parameter int NBITS   = 32,
  parameter int N_WORDS = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  output logic             o_mem_rd_en,
  output logic [NBITS-1:0] o_mem_addr,
  input  logic [NBITS-1:0] i_mem_data,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_start,
  input  logic             i_tx_done,
  output logic             o_busy,
  output logic             o_done
);

  localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int N_BYTES = NBITS / 8;
  localparam int BC_W    = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_WORDS - 1);
  localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(N_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_SEND,
    S_WAIT_TX,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   word_idx_q, word_idx_d;
  logic [BC_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [NBITS-1:0]   shreg_q, shreg_d;

  // Output registers. Their next values are decoded from the next state so
  // that each registered output lines up with the state it belongs to.
  logic               rd_en_q, rd_en_d;
  logic [NBITS-1:0]   addr_q, addr_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= S_IDLE;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      shreg_q    <= '0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      byte_cnt_q <= byte_cnt_d;
      shreg_q    <= shreg_d;
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    shreg_d    = shreg_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          word_idx_d = '0;
          byte_cnt_d = '0;
          state_d    = S_READ;
        end
      end
      S_READ: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        // Memory read latency is a fixed single cycle, no handshake.
        shreg_d = i_mem_data;
        state_d = S_SEND;
      end
      S_SEND: begin
        // A done arriving here belongs to nothing we sent; it is ignored.
        state_d = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (i_tx_done) begin
          shreg_d = shreg_q << 8;
          if (byte_cnt_q != LAST_BYTE) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            state_d    = S_SEND;
          end else if (word_idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            word_idx_d = word_idx_q + 1'b1;
            byte_cnt_d = '0;
            state_d    = S_READ;
          end
        end
      end
      S_DONE: begin
        word_idx_d = '0;
        byte_cnt_d = '0;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered-output decode, keyed on the state being entered.
  always_comb begin
    rd_en_d    = 1'b0;
    addr_d     = '0;
    tx_data_d  = '0;
    tx_start_d = 1'b0;
    done_d     = 1'b0;
    busy_d     = (state_d != S_IDLE);

    case (state_d)
      S_READ: begin
        rd_en_d = 1'b1;
        addr_d  = NBITS'(word_idx_d) << 2;
      end
      S_SEND: begin
        tx_start_d = 1'b1;
        tx_data_d  = shreg_d[NBITS-1 -: 8];
      end
      S_WAIT_TX: begin
        tx_data_d = tx_data_q;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign o_mem_rd_en = rd_en_q;
  assign o_mem_addr  = addr_q;
  assign o_tx_data   = tx_data_q;
  assign o_tx_start  = tx_start_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule
